// File: rtl/vae_win_pkg.sv
// Shared constants and FSM encoding for the 3x3 window path of the VAE level-1 datapath.
package vae_win_pkg;

   localparam int N_IN  = 9;
   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/win_sreg_9x16_en.sv
// Shift-enable-gated serial-in/parallel-out window register; word 0 (low bits) holds the newest sample.
module win_sreg_9x16_en #(
   parameter int N_IN  = vae_win_pkg::N_IN,
   parameter int WIDTH = vae_win_pkg::WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    shift_en,
   input  logic [WIDTH-1:0]        in_serial,
   output logic [N_IN*WIDTH-1:0]   out_parallel
);

   logic [N_IN*WIDTH-1:0] win_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         win_q <= '0;
      end else if (shift_en) begin
         win_q <= {win_q[(N_IN-1)*WIDTH-1:0], in_serial};
      end
   end

   assign out_parallel = win_q;

endmodule

// File: rtl/sipo_window_ctrl.sv
// Sequences 16-bit samples into 3x3 windows and hands each window to the MAC stage,
// counting windows per frame and pulsing done at the end of the frame.
module sipo_window_ctrl #(
   parameter int N_IN  = vae_win_pkg::N_IN,
   parameter int WIDTH = vae_win_pkg::WIDTH,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        n_win,
   input  logic                    s_valid,
   input  logic [WIDTH-1:0]        s_data,
   output logic                    s_ready,
   output logic                    m_valid,
   output logic [N_IN*WIDTH-1:0]   m_data,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done
);

   import vae_win_pkg::*;

   localparam int CW = $clog2(N_IN);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [CNT_W-1:0] win_idx_q;
   logic [CNT_W-1:0] n_win_q;
   logic             m_last_q;
   logic             done_q;
   logic             accept;

   assign accept = s_valid && (state_q == FILL);

   win_sreg_9x16_en #(
      .N_IN  (N_IN),
      .WIDTH (WIDTH)
   ) u_sreg (
      .clk          (clk),
      .rst          (rst),
      .shift_en     (accept),
      .in_serial    (s_data),
      .out_parallel (m_data)
   );

   // Handshake outputs decode the state only, so no input reaches an output combinationally.
   assign s_ready = (state_q == FILL);
   assign m_valid = (state_q == HOLD);
   assign busy    = (state_q != IDLE);
   assign m_last  = m_last_q;
   assign done    = done_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         win_idx_q <= '0;
         n_win_q   <= '0;
         m_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (n_win != '0) begin
                     n_win_q   <= n_win;
                     cnt_q     <= '0;
                     win_idx_q <= '0;
                     state_q   <= FILL;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (accept) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q    <= '0;
                     // win_idx is frozen in HOLD, so m_last can be settled on entry.
                     m_last_q <= (win_idx_q == n_win_q - CNT_W'(1));
                     state_q  <= HOLD;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_last_q <= 1'b0;
                  if (m_last_q) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     win_idx_q <= win_idx_q + CNT_W'(1);
                     state_q   <= FILL;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_window_ctrl.sv
// Scoreboard bench for sipo_window_ctrl: a queue-based window model feeds expectations to an output monitor.
module tb_sipo_window_ctrl;

   localparam int N_IN  = 9;
   localparam int WIDTH = 16;
   localparam int CNT_W = 16;
   localparam int MW    = N_IN * WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] n_win = '0;
   logic             s_valid = 1'b0;
   logic [WIDTH-1:0] s_data = '0;
   logic             s_ready;
   logic             m_valid;
   logic [MW-1:0]    m_data;
   logic             m_ready = 1'b0;
   logic             m_last;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   sipo_window_ctrl #(.N_IN(N_IN), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .n_win   (n_win),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready),
      .m_last  (m_last),
      .busy    (busy),
      .done    (done)
   );

   typedef struct {
      logic [MW-1:0] data;
      logic          last;
   } win_t;

   int n_checks = 0;
   int n_fail   = 0;

   win_t             exp_q[$];
   logic [WIDTH-1:0] acc[$];
   int               m_nwin = 0;
   int               m_widx = 0;
   bit               mon_en = 0;
   bit               zl_expect = 0;
   int               done_seen = 0;
   int               exp_done = 0;
   int               cyc = 0;
   int               last_gap = 0;
   int               mr_mode = 0;

   task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: the window is simply the last N_IN accepted samples, newest in word 0.
   always @(negedge clk) begin
      if (rst && s_valid && s_ready) begin
         acc.push_back(s_data);
         if (acc.size() == N_IN) begin
            win_t w;
            for (int k = 0; k < N_IN; k++) w.data[k*WIDTH +: WIDTH] = acc[N_IN-1-k];
            w.last = (m_widx == m_nwin - 1);
            exp_q.push_back(w);
            m_widx++;
            acc.delete();
         end
      end
   end

   // Output monitor.
   logic [MW-1:0] held;
   bit            holding = 0;
   bit            done_due = 0;
   bit            cur_last = 0;
   int            prev_rise = 0;
   win_t          mw;

   always @(posedge clk) begin
      cyc++;
      #2;
      if (!mon_en) begin
         holding  = 0;
         done_due = 0;
      end else begin
         if (done_due) begin
            chk("done_pulse", MW'(done), MW'(1));
            chk("done_busy_low", MW'(busy), MW'(0));
            done_due = 0;
         end else if (done && !zl_expect) begin
            chk("done_spurious", MW'(done), MW'(0));
         end
         if (done) done_seen++;
         if (!m_valid && exp_q.size() > 0) chk("valid_latency", MW'(m_valid), MW'(1));
         if (m_valid) begin
            chk("s_ready_in_hold", MW'(s_ready), MW'(0));
            if (!holding) begin
               if (exp_q.size() == 0) begin
                  chk("window_unexpected", MW'(m_valid), MW'(0));
                  cur_last = 0;
               end else begin
                  mw = exp_q.pop_front();
                  chk("m_data", m_data, mw.data);
                  chk("m_last", MW'(m_last), MW'(mw.last));
                  cur_last  = mw.last;
                  last_gap  = cyc - prev_rise;
                  prev_rise = cyc;
               end
               held    = m_data;
               holding = 1;
            end else begin
               chk("m_data_stable", m_data, held);
            end
            if (m_ready) begin
               holding = 0;
               if (cur_last) done_due = 1;
            end
         end else begin
            holding = 0;
         end
      end
   end

   // Downstream ready generator.
   int hold_cnt = 0;
   always @(posedge clk) begin
      #1;
      case (mr_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         default: begin
            if (m_valid && hold_cnt < 5) begin
               m_ready = 1'b0;
               hold_cnt++;
            end else begin
               m_ready = 1'b1;
               if (!m_valid) hold_cnt = 0;
            end
         end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mon_en  = 0;
      rst     = 1'b0;
      s_valid = 1'b1;
      start   = 1'b1;
      n_win   = CNT_W'(5);
      exp_q.delete();
      acc.delete();
      repeat (2) tick();
      chk("rst_s_ready", MW'(s_ready), MW'(0));
      chk("rst_m_valid", MW'(m_valid), MW'(0));
      chk("rst_m_last", MW'(m_last), MW'(0));
      chk("rst_busy", MW'(busy), MW'(0));
      chk("rst_done", MW'(done), MW'(0));
      chk("rst_m_data", m_data, MW'(0));
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_after_reset", MW'(busy), MW'(0));
      end
      mon_en = 1;
   endtask

   task automatic start_frame(input int n);
      m_nwin = n;
      m_widx = 0;
      acc.delete();
      start  = 1'b1;
      n_win  = CNT_W'(n);
      tick();
      start  = 1'b0;
      n_win  = CNT_W'($urandom);
      chk("busy_rise", MW'(busy), MW'(1));
   endtask

   task automatic send(input logic [WIDTH-1:0] v, input bit bub, input bit poke);
      int  t;
      bit  real_v;
      bit  took;
      t = 0;
      forever begin
         s_valid = 1'b1;
         real_v  = !m_valid;
         s_data  = real_v ? v : WIDTH'($urandom);
         start   = (poke && s_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         took = s_ready && real_v;
         tick();
         if (took) break;
         t++;
         if (t > 200) begin
            chk("send_timeout", MW'(0), MW'(1));
            break;
         end
      end
      start = 1'b0;
      if (bub) begin
         s_valid = 1'b0;
         s_data  = WIDTH'($urandom);
         tick();
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 500) begin
         tick();
         t++;
      end
      chk("frame_end", MW'(busy), MW'(0));
      tick();
      tick();
      chk("exp_q_drained", MW'(exp_q.size()), MW'(0));
   endtask

   task automatic run_frame(input int n, input int base, input bit bub, input bit rnd, input bit poke);
      start_frame(n);
      for (int w = 0; w < n; w++)
         for (int i = 0; i < N_IN; i++)
            send(rnd ? WIDTH'($urandom) : WIDTH'(base + w*N_IN + i), bub, poke);
      s_valid = 1'b0;
      wait_idle();
      exp_done++;
   endtask

   task automatic zero_frame();
      zl_expect = 1;
      start = 1'b1;
      n_win = '0;
      tick();
      start = 1'b0;
      chk("zl_done", MW'(done), MW'(1));
      chk("zl_busy", MW'(busy), MW'(0));
      chk("zl_s_ready", MW'(s_ready), MW'(0));
      tick();
      chk("zl_done_once", MW'(done), MW'(0));
      chk("zl_busy_after", MW'(busy), MW'(0));
      zl_expect = 0;
      exp_done++;
   endtask

   initial begin
      #1;
      do_reset();

      mr_mode = 0;
      run_frame(1, 1, 0, 0, 0);

      mr_mode = 2;
      run_frame(2, 1, 0, 0, 0);

      mr_mode = 0;
      run_frame(1, 1, 1, 0, 0);

      zero_frame();

      start_frame(3);
      for (int i = 0; i < 4; i++) send(WIDTH'(40 + i), 0, 0);
      s_valid = 1'b0;
      do_reset();
      run_frame(1, 21, 0, 0, 0);

      mr_mode = 0;
      run_frame(3, 100, 0, 0, 0);
      chk("throughput_gap", MW'(last_gap), MW'(N_IN + 1));

      mr_mode = 1;
      for (int f = 0; f < 6; f++) begin
         if (f == 3) zero_frame();
         run_frame($urandom_range(1, 4), 0, 1'($urandom_range(0, 1)), 1, 1);
      end

      chk("done_count", MW'(done_seen), MW'(exp_done));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sipo_window_ctrl.md
# sipo_window_ctrl

Sequencing controller for the 9-word x 16-bit window path in the VAE level-1 datapath. It accepts a valid/ready stream of 16-bit samples from the feature-map reader and shifts them into a shift-enable-gated serial-in/parallel-out window register. It presents each completed 3x3 window (144 bits) to the downstream MAC stage over a valid/ready handshake. It counts windows per frame and reports the end of the frame.

## Interface
- N_IN, 9, words per window
- WIDTH, 16, bits per word
- CNT_W, 16, width of the window counter and of `n_win`

- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  starts a frame; sampled in IDLE only
- n_win  in  CNT_W  windows in the frame; latched on an accepted `start`
- s_valid  in  1  input sample valid
- s_data  in  WIDTH  input sample
- s_ready  out  1  controller accepts a sample
- m_valid  out  1  window valid
- m_data  out  N_IN*WIDTH  window; word k occupies bits [WIDTH*(k+1)-1 : WIDTH*k]; word 0 is the newest sample
- m_ready  in  1  downstream accepts the window
- m_last  out  1  marks the final window of the frame; qualified by `m_valid`
- busy  out  1  high in FILL and HOLD
- done  out  1  one-cycle pulse at the end of the frame

## Operation
- States: IDLE, FILL, HOLD. Registers: `cnt` (0..N_IN-1), `win_idx` (CNT_W bits), `n_win_q`, window register.
- IDLE: `s_ready`=0, `m_valid`=0, `busy`=0.
  - On `start`=1 with `n_win`!=0: latch `n_win_q`=`n_win`, set `cnt`=0 and `win_idx`=0, go to FILL.
  - On `start`=1 with `n_win`==0: pulse `done` for one cycle and stay in IDLE.
- FILL: `s_ready`=1.
  - An accept is `s_valid & s_ready`. On each accept, word k moves to word k+1, word N_IN-1 is discarded, and `s_data` is written to word 0.
  - Each accept increments `cnt`.
  - The accept at `cnt`==N_IN-1 sets `cnt`=0 and moves to HOLD.
- HOLD: `m_valid`=1, `s_ready`=0, `m_data` held stable. `m_last` = (`win_idx`==`n_win_q`-1).
  - On `m_ready`=1 with `m_last`=1: go to IDLE and pulse `done` in the following cycle.
  - On `m_ready`=1 with `m_last`=0: increment `win_idx` and go to FILL.
- Every window overwrites all N_IN words. The window register is not cleared between windows or frames.
- `start` is ignored outside IDLE.
- `s_valid` is ignored in IDLE and HOLD.
- `m_ready` is ignored when `m_valid`=0.
- `n_win` changes after latch have no effect.

## Timing
- `rst`=0 at a rising edge forces the following reset values, regardless of state (mid-FILL or mid-HOLD aborts the frame):
  - state = IDLE
  - `s_ready`, `m_valid`, `m_last`, `busy`, `done` = 0
  - `m_data` = 0, `cnt` = 0, `win_idx` = 0, `n_win_q` = 0
- `busy` rises in the cycle after an accepted `start`.
- `m_valid` rises in the cycle after the 9th accept edge.
- With `s_valid` and `m_ready` held high, the controller delivers 1 window per N_IN+1 = 10 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `s_valid` or `m_ready` to any output.
- `done` is high for exactly one cycle and coincides with `busy`=0.

## Structure
- Shared package `vae_win_pkg` holds:
  - constants N_IN and WIDTH
  - state encoding: IDLE=2'd0, FILL=2'd1, HOLD=2'd2
- Sub-module `win_sreg_9x16_en` is the window register:
  - ports: `clk`, `rst`, `shift_en`, `in_serial`, `out_parallel`
  - shifts only when `shift_en`=1
  - this controller drives `shift_en` with the FILL accept
- The FSM and counters stay in `sipo_window_ctrl`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `s_valid`=1 and `start`=1 -> all outputs 0; after release the block stays in IDLE until `start`.
- Single window: `start` with `n_win`=1, then samples 1..9 back to back with `m_ready`=1 -> `m_valid` one cycle after the 9th accept.
  - `m_data` has word 8=1 through word 0=9, and `m_last`=1.
  - `done` pulses on the next cycle and `busy` falls.
- Backpressure: `n_win`=2, hold `m_ready`=0 for 5 cycles in HOLD while `s_data` keeps changing -> `m_data` stable and `s_ready`=0.
  - The second window, built from samples 10..18, has word 0=18.
  - `m_last` is set only on the second window.
- Source bubbles: drive `s_valid` as 1,0,1,0,... -> `cnt` advances only on accepts; the window is identical to the contiguous case.
- Zero-length frame: `start` with `n_win`=0 -> `done` pulses one cycle later; `s_ready` and `busy` never go high.
- Reset mid-FILL: reset after 4 accepts, then a new `start` with samples 21..29 -> the window contains only 21..29 (word 0=29).
